// File: rtl/uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_loader_pkg
// Shared definitions for the UART program-image loader:
//   - load_state_t : loader FSM state encoding
//   - BYTES_PER_WORD / BYTE_IDX_W : little-endian byte packing geometry
// -----------------------------------------------------------------------------
package uart_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FIRST = 2'd1,
      ST_RECV       = 2'd2,
      ST_DONE       = 2'd3
   } load_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/uart_idle_timer.sv
// -----------------------------------------------------------------------------
// uart_idle_timer
// Cycle counter used to detect an idle receive line.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear (wins over en)
//   en      : count enable
//   expire  : one-cycle pulse while the count sits at TIMEOUT_CYC-1, enabled
//             and not being cleared in the same cycle
// -----------------------------------------------------------------------------
module uart_idle_timer #(
   parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic             at_term;

   assign at_term = (cnt_reg == TERM_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en && !at_term) begin
         // Saturate at the terminal count so a stalled consumer never wraps.
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // A clear in the terminal cycle (new byte) suppresses the expiry.
   assign expire = en && !clr && at_term;

endmodule

// File: rtl/uart_word_loader.sv
// -----------------------------------------------------------------------------
// uart_word_loader
// Packs the UART receive byte stream little-endian into 32-bit words and writes
// them to consecutive memory word addresses. A load runs while load_en is high
// and ends on line-idle timeout, on reaching MAX_WORDS, or when load_en drops.
//   sys_clk     : system clock, rising edge
//   sys_rst_n   : asynchronous active-low reset
//   load_en     : 1 = loader active (CPU held)
//   rx_valid    : one-cycle pulse, rx_data holds a new byte
//   rx_data     : received byte
//   mem_we      : one-cycle write strobe
//   mem_addr    : word address of the write (held until next write)
//   mem_wdata   : word written (held until next write)
//   load_busy   : high while waiting for / receiving bytes
//   load_done   : high once the load has finished, until load_en drops
//   partial_err : load timed out with 1-3 orphan bytes (discarded)
//   word_count  : words written in the current or last load
// -----------------------------------------------------------------------------
module uart_word_loader
   import uart_loader_pkg::*;
#(
   parameter int CLK_FREQ         = 100_000_000,
   parameter int ADDR_WIDTH       = 14,
   parameter int MAX_WORDS        = 16384,
   parameter int IDLE_TIMEOUT_CYC = 10_000_000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  load_en,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  partial_err,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int BUF_W = 8 * (BYTES_PER_WORD - 1);
   localparam logic [ADDR_WIDTH:0]   LAST_WORD = (ADDR_WIDTH + 1)'(MAX_WORDS - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_IDX  = BYTE_IDX_W'(BYTES_PER_WORD - 1);

   if (MAX_WORDS < 1 || MAX_WORDS > (1 << ADDR_WIDTH) || CLK_FREQ < 1 ||
       IDLE_TIMEOUT_CYC < 1) begin : g_param_check
      $error("uart_word_loader: invalid parameter set");
   end

   load_state_t           state_reg, state_next;
   logic [BYTE_IDX_W-1:0] byte_idx_reg, byte_idx_next;
   logic [BUF_W-1:0]      word_buf_reg, word_buf_next;
   logic [ADDR_WIDTH:0]   word_count_reg, word_count_next;
   logic                  mem_we_reg, mem_we_next;
   logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
   logic [31:0]           mem_wdata_reg, mem_wdata_next;
   logic                  partial_err_reg, partial_err_next;

   logic [31:0]           word_assembled;
   logic                  timer_clr;
   logic                  timer_en;
   logic                  timer_expire;

   // Buffered bytes with the incoming byte merged into its lane. The top lane
   // is never buffered: the byte landing there completes the word directly.
   for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      assign word_assembled[8*gi +: 8] =
         (byte_idx_reg == BYTE_IDX_W'(gi)) ? rx_data : word_buf_reg[8*gi +: 8];
   end
   assign word_assembled[BUF_W +: 8] = rx_data;

   // Timer only runs in RECV; WAIT_FIRST has no timeout.
   assign timer_en  = (state_reg == ST_RECV);
   assign timer_clr = rx_valid || (state_reg != ST_RECV);

   uart_idle_timer #(
      .TIMEOUT_CYC(IDLE_TIMEOUT_CYC)
   ) u_idle_timer (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .clr    (timer_clr),
      .en     (timer_en),
      .expire (timer_expire)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg       <= ST_IDLE;
         byte_idx_reg    <= '0;
         word_buf_reg    <= '0;
         word_count_reg  <= '0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         partial_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         byte_idx_reg    <= byte_idx_next;
         word_buf_reg    <= word_buf_next;
         word_count_reg  <= word_count_next;
         mem_we_reg      <= mem_we_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         partial_err_reg <= partial_err_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      byte_idx_next    = byte_idx_reg;
      word_buf_next    = word_buf_reg;
      word_count_next  = word_count_reg;
      mem_we_next      = 1'b0;
      mem_addr_next    = mem_addr_reg;
      mem_wdata_next   = mem_wdata_reg;
      partial_err_next = partial_err_reg;

      if (!load_en) begin
         // Abort from any state; a write already registered still completes
         // because mem_we_reg is not touched here. word_count holds.
         state_next       = ST_IDLE;
         byte_idx_next    = '0;
         partial_err_next = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next       = ST_WAIT_FIRST;
               word_count_next  = '0;
               byte_idx_next    = '0;
               partial_err_next = 1'b0;
            end

            ST_WAIT_FIRST: begin
               if (rx_valid) begin
                  word_buf_next = word_assembled[BUF_W-1:0];
                  byte_idx_next = byte_idx_reg + BYTE_IDX_W'(1);
                  state_next    = ST_RECV;
               end
            end

            ST_RECV: begin
               if (rx_valid) begin
                  if (byte_idx_reg == LAST_IDX) begin
                     mem_we_next     = 1'b1;
                     mem_addr_next   = word_count_reg[ADDR_WIDTH-1:0];
                     mem_wdata_next  = word_assembled;
                     word_count_next = word_count_reg + (ADDR_WIDTH + 1)'(1);
                     byte_idx_next   = '0;
                     // Entering DONE on the same edge as the final strobe makes
                     // load_done rise together with the last mem_we.
                     if (word_count_reg == LAST_WORD) begin
                        state_next = ST_DONE;
                     end
                  end else begin
                     word_buf_next = word_assembled[BUF_W-1:0];
                     byte_idx_next = byte_idx_reg + BYTE_IDX_W'(1);
                  end
               end else if (timer_expire) begin
                  state_next = ST_DONE;
                  if (byte_idx_reg != '0) begin
                     partial_err_next = 1'b1;
                  end
                  byte_idx_next = '0;
               end
            end

            ST_DONE: begin
               state_next = ST_DONE;
            end

            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign mem_we      = mem_we_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign word_count  = word_count_reg;
   assign partial_err = partial_err_reg;
   assign load_done   = (state_reg == ST_DONE);
   assign load_busy   = (state_reg == ST_WAIT_FIRST) || (state_reg == ST_RECV);

endmodule

// File: tb/tb_uart_word_loader.sv
module tb_uart_word_loader;

   localparam int AW   = 14;
   localparam int MAXW = 4;
   localparam int TMO  = 100;

   logic          sys_clk;
   logic          sys_rst_n;
   logic          load_en;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          load_busy;
   logic          load_done;
   logic          partial_err;
   logic [AW:0]   word_count;

   uart_word_loader #(
      .CLK_FREQ         (100_000_000),
      .ADDR_WIDTH       (AW),
      .MAX_WORDS        (MAXW),
      .IDLE_TIMEOUT_CYC (TMO)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .load_en     (load_en),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .load_busy   (load_busy),
      .load_done   (load_done),
      .partial_err (partial_err),
      .word_count  (word_count)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cyc;
      logic          done;
   } wr_t;

   wr_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   logic        m_active = 1'b0;
   int          m_idx    = 0;
   int          m_count  = 0;
   logic [31:0] m_word   = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every strobe must match the oldest expected write
   logic prev_we = 1'b0;
   always @(negedge sys_clk) begin
      if (mem_we) begin
         wr_t e;
         chk("we_not_back_to_back", {63'd0, prev_we}, 64'd0);
         chk("we_expected", {63'd0, exp_q.size() != 0}, 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("we_addr", {50'd0, mem_addr}, {50'd0, e.addr});
            chk("we_data", {32'd0, mem_wdata}, {32'd0, e.data});
            chk("we_latency", 64'(cyc), 64'(e.cyc));
            chk("done_at_we", {63'd0, load_done}, {63'd0, e.done});
            $display("write addr=%0d data=%08h cyc=%0d", mem_addr, mem_wdata, cyc);
         end
      end
      prev_we = mem_we;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // drive one byte pulse at a negedge; pulses are `gap` cycles apart
   task automatic send_byte(input logic [7:0] b, input int gap);
      wr_t e;
      rx_data  = b;
      rx_valid = 1'b1;
      if (m_active) begin
         m_word[8*m_idx +: 8] = b;
         if (m_idx == 3) begin
            e.addr = AW'(m_count);
            e.data = m_word;
            e.cyc  = cyc + 1;
            e.done = (m_count == MAXW - 1);
            exp_q.push_back(e);
            m_count++;
            if (m_count == MAXW) m_active = 1'b0;
         end
         m_idx = (m_idx + 1) % 4;
      end
      @(negedge sys_clk);
      rx_valid = 1'b0;
      tick(gap - 1);
   endtask

   task automatic start_load();
      load_en  = 1'b1;
      m_active = 1'b1;
      m_idx    = 0;
      m_count  = 0;
      tick(2);
      chk("start_busy", {63'd0, load_busy}, 64'd1);
      chk("start_count", 64'(word_count), 64'd0);
   endtask

   task automatic end_load();
      load_en  = 1'b0;
      m_active = 1'b0;
      tick(2);
      chk("idle_done_clear", {63'd0, load_done}, 64'd0);
      chk("idle_perr_clear", {63'd0, partial_err}, 64'd0);
   endtask

   task automatic wait_done(input int exp_count, input logic exp_perr);
      for (int i = 0; i < 400 && !load_done; i++) @(negedge sys_clk);
      chk("done_reached", {63'd0, load_done}, 64'd1);
      chk("done_busy", {63'd0, load_busy}, 64'd0);
      chk("done_count", 64'(word_count), 64'(exp_count));
      chk("done_perr", {63'd0, partial_err}, {63'd0, exp_perr});
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      sys_rst_n = 1'b1;
      load_en   = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      #2 sys_rst_n = 1'b0;
      tick(3);
      chk("rst_we", {63'd0, mem_we}, 64'd0);
      chk("rst_addr", {50'd0, mem_addr}, 64'd0);
      chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
      chk("rst_busy", {63'd0, load_busy}, 64'd0);
      chk("rst_done", {63'd0, load_done}, 64'd0);
      chk("rst_perr", {63'd0, partial_err}, 64'd0);
      chk("rst_count", 64'(word_count), 64'd0);
      sys_rst_n = 1'b1;
      tick(2);

      // bytes while idle are ignored
      send_byte(8'hEE, 10);
      chk("idle_ignores_rx", {63'd0, load_busy}, 64'd0);

      // 1: single word, exact timeout boundary
      $display("step 1 single word");
      start_load();
      send_byte(8'h78, 10);
      send_byte(8'h56, 10);
      send_byte(8'h34, 10);
      send_byte(8'h12, 10);
      tick(90);
      chk("timeout_not_early", {63'd0, load_done}, 64'd0);
      tick(1);
      chk("timeout_on_time", {63'd0, load_done}, 64'd1);
      wait_done(1, 1'b0);
      chk("addr_hold", {50'd0, mem_addr}, 64'd0);
      chk("wdata_hold", {32'd0, mem_wdata}, 64'h12345678);
      end_load();

      // 2: two words
      $display("step 2 two words");
      start_load();
      for (int i = 0; i < 8; i++) send_byte(8'(i), 10);
      wait_done(2, 1'b0);
      end_load();

      // 3: orphan bytes
      $display("step 3 partial word");
      start_load();
      for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 10);
      wait_done(1, 1'b1);
      end_load();
      chk("count_holds_idle", 64'(word_count), 64'd1);

      // 4: capacity
      $display("step 4 capacity");
      start_load();
      for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i), 10);
      wait_done(MAXW, 1'b0);
      end_load();

      // 5: abort after 2 bytes, restart, WAIT_FIRST has no timeout
      $display("step 5 abort and restart");
      start_load();
      send_byte(8'hB0, 10);
      send_byte(8'hB1, 10);
      end_load();
      chk("abort_not_busy", {63'd0, load_busy}, 64'd0);
      start_load();
      tick(500);
      chk("wait_first_busy", {63'd0, load_busy}, 64'd1);
      chk("wait_first_no_done", {63'd0, load_done}, 64'd0);
      send_byte(8'hC0, 10);
      send_byte(8'hC1, 10);
      send_byte(8'hC2, 10);
      send_byte(8'hC3, 10);
      wait_done(1, 1'b0);
      chk("restart_wdata", {32'd0, mem_wdata}, 64'hC3C2C1C0);
      end_load();

      // 6: byte on the terminal count wins
      $display("step 6 byte on terminal count");
      start_load();
      send_byte(8'h11, 10);
      send_byte(8'h22, TMO);
      chk("term_byte_wins_1", {63'd0, load_done}, 64'd0);
      send_byte(8'h33, TMO);
      chk("term_byte_wins_2", {63'd0, load_done}, 64'd0);
      send_byte(8'h44, 10);
      wait_done(1, 1'b0);
      chk("term_wdata", {32'd0, mem_wdata}, 64'h44332211);
      end_load();

      // 7: asynchronous reset while the 4th byte of a word is on the bus
      $display("step 7 async reset mid-word");
      start_load();
      for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 10);
      rx_data  = 8'h57;
      rx_valid = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_we", {63'd0, mem_we}, 64'd0);
      chk("arst_addr", {50'd0, mem_addr}, 64'd0);
      chk("arst_wdata", {32'd0, mem_wdata}, 64'd0);
      chk("arst_busy", {63'd0, load_busy}, 64'd0);
      chk("arst_count", 64'(word_count), 64'd0);
      load_en  = 1'b0;
      m_active = 1'b0;
      @(negedge sys_clk);
      rx_valid = 1'b0;
      tick(3);
      sys_rst_n = 1'b1;
      tick(20);
      chk("arst_no_pending", 64'(exp_q.size()), 64'd0);
      chk("arst_idle", {63'd0, load_busy}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
